// File: rtl/carry_seq.sv
// Nibble-serial adder: ripples one 4-bit slice per clock through a registered carry.
// Optional signed-overflow output OVF is built only when CARRY_SEQ_OVF_EN is defined.
module carry_seq #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         CIN,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] SUM,
`ifdef CARRY_SEQ_OVF_EN
    output logic         OVF,
`endif
    output logic         COUT
);

    // state | meaning
    // IDLE  | waiting for START
    // RUN   | adding nibble idx_q each cycle
    // FIN   | result valid (DONE), START accepted here too
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [3:0] LAST = 4'(NIBBLES - 1);

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic           c_q, c_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic [5:0]     pos;
    logic [3:0]     a_nib, b_nib;
    logic [4:0]     nib;
`ifdef CARRY_SEQ_OVF_EN
    logic           ovf_q, ovf_d;
    logic [3:0]     low3;
`endif

    assign pos   = {idx_q, 2'b00};
    assign a_nib = a_q[pos +: 4];
    assign b_nib = b_q[pos +: 4];
    assign nib   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, c_q};
`ifdef CARRY_SEQ_OVF_EN
    // Carry into the top bit of the slice, needed for the signed-overflow XOR.
    assign low3  = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, c_q};
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef CARRY_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = CIN;
                    idx_d   = 4'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[pos +: 4] = nib[3:0];
                c_d             = nib[4];
                idx_d           = idx_q + 4'd1;
                if (idx_q == LAST) begin
                    state_d = FIN;
                    cout_d  = nib[4];
`ifdef CARRY_SEQ_OVF_EN
                    ovf_d   = low3[3] ^ nib[4];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CARRY_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef CARRY_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == FIN);
    assign SUM  = sum_q;
    assign COUT = cout_q;
`ifdef CARRY_SEQ_OVF_EN
    assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_carry_seq.sv
// Directed bench for carry_seq (NIBBLES=4) with a queue of expected results.
// OVF checks are compiled in only when CARRY_SEQ_OVF_EN is defined.
module tb_carry_seq;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [15:0] A;
    logic [15:0] B;
    logic        CIN;
    logic        BUSY;
    logic        DONE;
    logic [15:0] SUM;
    logic        COUT;
`ifdef CARRY_SEQ_OVF_EN
    logic        OVF;
`endif

    carry_seq #(.NIBBLES(4)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .START(START),
        .A    (A),
        .B    (B),
        .CIN  (CIN),
        .BUSY (BUSY),
        .DONE (DONE),
        .SUM  (SUM),
`ifdef CARRY_SEQ_OVF_EN
        .OVF  (OVF),
`endif
        .COUT (COUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] t;
        exp_t        e;
        t      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        e.sum  = t[15:0];
        e.cout = t[16];
        e.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
        sb.push_back(e);
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
        A     = a;
        B     = b;
        CIN   = cin;
        START = 1'b1;
        push_exp(a, b, cin);
        cycle();
        START = 1'b0;
        chk("busy_after_start", BUSY, 1);
        chk("no_done_in_run", DONE, 0);
    endtask

    // Waits for DONE, checking remaining latency and BUSY length, then scores the result.
    task automatic wait_done(input string tag, input int exp_lat);
        int   n    = 0;
        int   busy = 0;
        exp_t e;
        while (!DONE && n < 20) begin
            if (BUSY) busy++;
            cycle();
            n++;
        end
        chk({tag, "_done"}, DONE, 1);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy_cycles"}, busy, exp_lat);
        chk({tag, "_busy_in_fin"}, BUSY, 0);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, SUM, e.sum);
            chk({tag, "_cout"}, COUT, e.cout);
`ifdef CARRY_SEQ_OVF_EN
            chk({tag, "_ovf"}, OVF, e.ovf);
`endif
        end
    endtask

    initial begin
        RST_N = 1'b0;
        START = 1'b0;
        A     = '0;
        B     = '0;
        CIN   = 1'b0;
        cycle();
        cycle();
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_cout", COUT, 0);
`ifdef CARRY_SEQ_OVF_EN
        chk("rst_ovf", OVF, 0);
`endif
        RST_N = 1'b1;
        cycle();
        chk("idle_busy", BUSY, 0);

        // Full carry ripple with wrap-around, then DONE must drop and results hold.
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done("ffff_1", 4);
        chk("ffff_1_sum_const", SUM, 16'h0000);
        chk("ffff_1_cout_const", COUT, 1);
        cycle();
        chk("done_one_cycle", DONE, 0);
        chk("idle_after_fin", BUSY, 0);
        chk("sum_hold", SUM, 16'h0000);
        chk("cout_hold", COUT, 1);

        // Unprocessed nibbles keep their old value until overwritten.
        start_op(16'h1234, 16'h4321, 1'b1);
        chk("sum_retained", SUM, 16'h0000);
        cycle();
        chk("sum_nib0_only", SUM, 16'h0006);
        wait_done("1234_4321", 3);
        chk("5556_const", SUM, 16'h5556);
        cycle();

        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done("7fff_1", 4);
        chk("8000_const", SUM, 16'h8000);
        cycle();

        // START and operand changes during RUN are ignored.
        start_op(16'h1111, 16'h2222, 1'b0);
        cycle();
        A     = 16'hFFFF;
        B     = 16'hFFFF;
        CIN   = 1'b1;
        START = 1'b1;
        cycle();
        START = 1'b0;
        wait_done("ignore_start", 2);
        chk("3333_const", SUM, 16'h3333);

        // START during the FIN cycle begins a new RUN on that edge.
        start_op(16'h8000, 16'h8000, 1'b1);
        wait_done("fin_restart", 4);

        // Reset in the second RUN cycle aborts without DONE.
        start_op(16'h5A5A, 16'hA5A5, 1'b1);
        cycle();
        RST_N = 1'b0;
        #1;
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        chk("abort_sum", SUM, 0);
        chk("abort_cout", COUT, 0);
        void'(sb.pop_back());
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("abort_no_done_rst", DONE, 0);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("abort_no_done_idle", DONE, 0);
            chk("abort_idle_busy", BUSY, 0);
        end
        start_op(16'hABCD, 16'h1234, 1'b0);
        wait_done("after_reset", 4);
        cycle();

        for (int i = 0; i < 6; i++) begin
            start_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                     1'($urandom_range(0, 1)));
            wait_done("random", 4);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
